// File: rtl/adder_seq_ctrl_if.sv
// adder_seq_ctrl_if: request/result bundle between a requester and adder_seq_ctrl.
//
// Signals
//   start_valid / start_ready  request handshake; a, b, cin qualify start_valid
//   sum, cout                  result, qualified by done_valid
//   done_valid / done_ready    result handshake
//   busy                       sequencer is running or holding a result
//
// Modports
//   master  requester side (drives request, consumes result)
//   slave   sequencer side
interface adder_seq_ctrl_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             done_valid;
   logic             done_ready;
   logic             busy;

   modport master (
      output start_valid, a, b, cin, done_ready,
      input  start_ready, sum, cout, done_valid, busy
   );

   modport slave (
      input  start_valid, a, b, cin, done_ready,
      output start_ready, sum, cout, done_valid, busy
   );
endinterface

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: adds two WIDTH-bit operands over N = WIDTH/SLICE cycles using one
// SLICE-bit ripple-carry slice, LSB slice first. The result is returned with a
// valid/ready handshake and held until taken.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   adder_seq_ctrl_if.slave: request (start_valid/ready, a, b, cin),
//         result (done_valid/ready, sum, cout) and busy status
//
// WIDTH must be a multiple of SLICE with at least two slices.
module adder_seq_ctrl #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SLICE = 4
) (
   input logic             clk,
   input logic             rst,
   adder_seq_ctrl_if.slave bus
);

   localparam int unsigned N    = WIDTH / SLICE;
   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, b_q, sum_q;
   logic              carry_q, cout_q;
   logic [CntW-1:0]   cnt_q;

   logic [SLICE-1:0]  slice_sum;
   logic              slice_cout;
   logic              rip_c;
   logic              accept;
   logic              last;

   assign accept = (state_q == StIdle) && bus.start_valid;
   assign last   = (cnt_q == CntW'(N - 1));

   // Slice adder: full-adder chain over the low SLICE bits of the shifting operands.
   always_comb begin
      slice_sum = '0;
      rip_c     = carry_q;
      for (int unsigned i = 0; i < SLICE; i++) begin
         slice_sum[i] = a_q[i] ^ b_q[i] ^ rip_c;
         rip_c        = (a_q[i] & b_q[i]) | (rip_c & (a_q[i] ^ b_q[i]));
      end
      slice_cout = rip_c;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start_valid)  state_d = StRun;
         StRun:   if (last)             state_d = StDone;
         StDone:  if (bus.done_ready)   state_d = StIdle;
         default:                       state_d = StIdle;
      endcase
   end

   // Datapath: operands shift out LSB-first, sum fills in from the top so that
   // after N slices the first slice lands at the bottom.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         a_q     <= bus.a;
         b_q     <= bus.b;
         carry_q <= bus.cin;
         cnt_q   <= '0;
      end else if (state_q == StRun) begin
         a_q     <= a_q >> SLICE;
         b_q     <= b_q >> SLICE;
         sum_q   <= {slice_sum, sum_q[WIDTH-1:SLICE]};
         carry_q <= slice_cout;
         cnt_q   <= cnt_q + CntW'(1);
         if (last) begin
            cout_q <= slice_cout;
         end
      end
   end

   // Outputs depend only on registered state.
   always_comb begin
      bus.start_ready = (state_q == StIdle);
      bus.busy        = (state_q != StIdle);
      bus.done_valid  = (state_q == StDone);
      bus.sum         = sum_q;
      bus.cout        = cout_q;
   end

endmodule
